// File: rtl/alu_cmd_ctrl.sv
// Purpose: sequences register-file loads and single ALU operations onto an external combinational ALU.
// Latency: done pulses 2 cycles after the accept edge for a load, 3 cycles for an ALU operation.
// Backpressure: cmd_ready is high only in IDLE; the upstream holds the command until it is accepted.
module alu_cmd_ctrl #(
    parameter int unsigned      WIDTH     = 2,
    parameter logic [WIDTH-1:0] REG_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    // command handshake
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_rd,
    input  logic [1:0]       cmd_ra,
    input  logic [1:0]       cmd_rb,
    input  logic [WIDTH-1:0] cmd_imm,
    // sticky overflow clear
    input  logic             clr_ovf,
    // debug register read
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    // external ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    // completion status
    output logic             done,
    output logic [WIDTH-1:0] last_result,
    output logic             last_ovf,
    output logic             ovf_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // register file
    logic [WIDTH-1:0] regs_q [4];
    logic [WIDTH-1:0] regs_d [4];

    // command fields captured at the accept edge; the live cmd_* inputs are
    // never looked at again once a command is in flight
    logic             load_q, load_d;
    logic [2:0]       op_q,   op_d;
    logic [1:0]       rd_q,   rd_d;
    logic [1:0]       ra_q,   ra_d;
    logic [1:0]       rb_q,   rb_d;
    logic [WIDTH-1:0] imm_q,  imm_d;

    // ALU drive registers: only updated on READ -> EXEC, otherwise they hold
    logic [WIDTH-1:0] alu_a_q,  alu_a_d;
    logic [WIDTH-1:0] alu_b_q,  alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;

    // completion status
    logic [WIDTH-1:0] last_result_q, last_result_d;
    logic             last_ovf_q,    last_ovf_d;
    logic             ovf_sticky_q,  ovf_sticky_d;

    // writeback request shared by load (READ) and ALU capture (EXEC)
    logic             wb_vld;
    logic [WIDTH-1:0] wb_dat;
    logic             ovf_set;

    // Next-state, command capture, operand fetch and writeback
    always_comb begin
        state_d       = state_q;
        regs_d        = regs_q;
        load_d        = load_q;
        op_d          = op_q;
        rd_d          = rd_q;
        ra_d          = ra_q;
        rb_d          = rb_q;
        imm_d         = imm_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        last_result_d = last_result_q;
        last_ovf_d    = last_ovf_q;
        wb_vld        = 1'b0;
        wb_dat        = '0;
        ovf_set       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load_d  = cmd_load;
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    imm_d   = cmd_imm;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (load_q) begin
                    wb_vld     = 1'b1;
                    wb_dat     = imm_q;
                    last_ovf_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    // operands are fetched here, one edge before the
                    // writeback, so aliased rd/ra/rb see the old value
                    alu_a_d  = regs_q[ra_q];
                    alu_b_d  = regs_q[rb_q];
                    alu_op_d = op_q;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU inputs have been stable for this whole cycle
                wb_vld     = 1'b1;
                wb_dat     = alu_result;
                last_ovf_d = alu_overflow;
                ovf_set    = alu_overflow;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wb_vld) begin
            regs_d[rd_q]  = wb_dat;
            last_result_d = wb_dat;
        end
    end

    // Sticky overflow: a capture with overflow beats a clear on the same edge
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (ovf_set) begin
            ovf_sticky_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset; reset abandons any in-flight command
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= REG_RESET;
            end
            load_q        <= 1'b0;
            op_q          <= '0;
            rd_q          <= '0;
            ra_q          <= '0;
            rb_q          <= '0;
            imm_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            last_result_q <= '0;
            last_ovf_q    <= 1'b0;
            ovf_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            load_q        <= load_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            imm_q         <= imm_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            last_result_q <= last_result_d;
            last_ovf_q    <= last_ovf_d;
            ovf_sticky_q  <= ovf_sticky_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign rd_data     = regs_q[rd_sel];
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign last_result = last_result_q;
    assign last_ovf    = last_ovf_q;
    assign ovf_sticky  = ovf_sticky_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl with a behavioural stand-in for the 2-bit ALU on the alu_* ports.
// Directed scenarios plus randomized commands checked against a register-file model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_cmd_ctrl;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_load = 1'b0;
    logic [2:0]     cmd_op = '0;
    logic [1:0]     cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic [W-1:0]   cmd_imm = '0;
    logic           clr_ovf = 1'b0;
    logic [1:0]     rd_sel = '0;
    logic [W-1:0]   rd_data, alu_a, alu_b, alu_result, last_result;
    logic [2:0]     alu_op;
    logic           alu_overflow, done, last_ovf, ovf_sticky;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic         ld;
        logic [2:0]   op;
        logic [1:0]   rd, ra, rb;
        logic [W-1:0] imm;
    } cmd_t;

    // reference state
    logic [W-1:0] m_regs [4];
    logic [W-1:0] m_last;
    logic         m_lovf, m_sticky;

    always #5 clk = ~clk;

    alu_cmd_ctrl #(.WIDTH(W), .REG_RESET('0)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .clr_ovf(clr_ovf), .rd_sel(rd_sel), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .done(done), .last_result(last_result), .last_ovf(last_ovf), .ovf_sticky(ovf_sticky)
    );

    // 2-bit ALU: {overflow, result}. Arithmetic overflow is the carry out; SUB is a + ~b + 1.
    function automatic logic [W:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            3'b010:  r = {1'b0, a} + (W+1)'(1);
            3'b011:  r = {(a == '0), a - W'(1)};
            3'b100:  r = {1'b0, a & b};
            3'b101:  r = {1'b0, a | b};
            3'b110:  r = {1'b0, a ^ b};
            default: r = {1'b0, ~a};
        endcase
        return r;
    endfunction

    assign {alu_overflow, alu_result} = alu_fn(alu_op, alu_a, alu_b);

    function automatic cmd_t mk(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                                input logic [1:0] ra, input logic [1:0] rb, input logic [W-1:0] imm);
        cmd_t c;
        c.ld = ld; c.op = op; c.rd = rd; c.ra = ra; c.rb = rb; c.imm = imm;
        return c;
    endfunction

    // Architectural effect of one completed command; clr_at != 0 means a clear landed before or on the capture
    task automatic model_apply(input cmd_t c, input int clr_at);
        logic [W:0] r;
        r = c.ld ? {1'b0, c.imm} : alu_fn(c.op, m_regs[c.ra], m_regs[c.rb]);
        if (clr_at != 0) m_sticky = 1'b0;
        if (!c.ld && r[W]) m_sticky = 1'b1;
        m_regs[c.rd] = r[W-1:0];
        m_last = r[W-1:0];
        m_lovf = c.ld ? 1'b0 : r[W];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_last = '0; m_lovf = 1'b0; m_sticky = 1'b0;
    endtask

    task automatic read_regs(output logic [3:0][W-1:0] r);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            r[i] = rd_data;
        end
    endtask

    // Issue one command, scramble cmd_* after acceptance, wait (bounded) for done.
    // lat counts falling edges after the accept edge; clr_ovf is high during falling-edge number clr_at.
    task automatic do_cmd(input cmd_t c, input int clr_at, output int lat, output int rdy_low,
                          output logic [W-1:0] ex_a, output logic [W-1:0] ex_b, output logic [2:0] ex_op);
        int guard;
        ex_a = '0; ex_b = '0; ex_op = '0;
        @(negedge clk);
        cmd_load = c.ld; cmd_op = c.op; cmd_rd = c.rd; cmd_ra = c.ra; cmd_rb = c.rb; cmd_imm = c.imm;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_load = 1'($urandom); cmd_op = 3'($urandom); cmd_rd = 2'($urandom);
        cmd_ra = 2'($urandom); cmd_rb = 2'($urandom); cmd_imm = W'($urandom);
        lat = 1;
        rdy_low = 0;
        while (lat < 10) begin
            clr_ovf = (lat == clr_at);
            if (!cmd_ready) rdy_low++;
            if (lat == 2) begin
                ex_a = alu_a; ex_b = alu_b; ex_op = alu_op;
            end
            if (done) break;
            @(negedge clk);
            lat++;
        end
        clr_ovf = 1'b0;
        model_apply(c, clr_at);
    endtask

    task automatic test_reset();
        logic [3:0][W-1:0] r;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (alu_a !== '0 || alu_b !== '0 || alu_op !== '0) begin miscompares++; $display("FAIL reset_alu_drive: got a=%0d b=%0d op=%0d want 0", alu_a, alu_b, alu_op); end
        vectors++; if (last_result !== '0 || last_ovf !== 1'b0 || ovf_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_status: got res=%0d lovf=%b sticky=%b want 0", last_result, last_ovf, ovf_sticky); end
        read_regs(r);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (r[i] !== '0) begin miscompares++; $display("FAIL reset_reg%0d: got %0d want 0", i, r[i]); end
        end
    endtask

    task automatic test_load();
        int lat, rl; logic [W-1:0] xa, xb; logic [2:0] xo; logic [3:0][W-1:0] r;
        do_cmd(mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 2'd3), 0, lat, rl, xa, xb, xo);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load0_latency: got %0d want 2", lat); end
        vectors++; if (rl !== 2) begin miscompares++; $display("FAIL load0_ready_low: got %0d want 2", rl); end
        vectors++; if (last_result !== 2'd3 || last_ovf !== 1'b0) begin miscompares++; $display("FAIL load0_status: got res=%0d lovf=%b want 3/0", last_result, last_ovf); end
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL load0_ready_back: got %b want 1", cmd_ready); end
        do_cmd(mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 2'd1), 0, lat, rl, xa, xb, xo);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load1_latency: got %0d want 2", lat); end
        vectors++; if (rl !== 2) begin miscompares++; $display("FAIL load1_ready_low: got %0d want 2", rl); end
        read_regs(r);
        vectors++; if (r[0] !== 2'd3) begin miscompares++; $display("FAIL load_r0: got %0d want 3", r[0]); end
        vectors++; if (r[1] !== 2'd1) begin miscompares++; $display("FAIL load_r1: got %0d want 1", r[1]); end
        vectors++; if (last_ovf !== 1'b0) begin miscompares++; $display("FAIL load1_lovf: got %b want 0", last_ovf); end
    endtask

    task automatic test_add_sub();
        int lat, rl; logic [W-1:0] xa, xb; logic [2:0] xo; logic [3:0][W-1:0] r;
        do_cmd(mk(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 2'd0), 0, lat, rl, xa, xb, xo);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL add_latency: got %0d want 3", lat); end
        vectors++; if (xa !== 2'd3 || xb !== 2'd1 || xo !== 3'b000) begin miscompares++; $display("FAIL add_alu_drive: got a=%0d b=%0d op=%0d want 3/1/0", xa, xb, xo); end
        read_regs(r);
        vectors++; if (r[2] !== 2'd0) begin miscompares++; $display("FAIL add_r2: got %0d want 0", r[2]); end
        vectors++; if (last_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL add_ovf: got lovf=%b sticky=%b want 1/1", last_ovf, ovf_sticky); end
        do_cmd(mk(1'b0, 3'b001, 2'd3, 2'd1, 2'd0, 2'd0), 0, lat, rl, xa, xb, xo);
        read_regs(r);
        vectors++; if (r[3] !== 2'd2) begin miscompares++; $display("FAIL sub_r3: got %0d want 2", r[3]); end
        vectors++; if (last_ovf !== 1'b0 || ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL sub_ovf: got lovf=%b sticky=%b want 0/1", last_ovf, ovf_sticky); end
    endtask

    task automatic test_inc_clr();
        int lat, rl; logic [W-1:0] xa, xb; logic [2:0] xo; logic [3:0][W-1:0] r;
        // clear coincides with the capture edge
        do_cmd(mk(1'b0, 3'b010, 2'd0, 2'd0, 2'd0, 2'd0), 2, lat, rl, xa, xb, xo);
        read_regs(r);
        vectors++; if (r[0] !== 2'd0 || last_ovf !== 1'b1) begin miscompares++; $display("FAIL inc_result: got r0=%0d lovf=%b want 0/1", r[0], last_ovf); end
        vectors++; if (ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL inc_set_wins: got %b want 1", ovf_sticky); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        m_sticky = 1'b0;
        vectors++; if (ovf_sticky !== 1'b0) begin miscompares++; $display("FAIL clr_ovf_later: got %b want 0", ovf_sticky); end
    endtask

    task automatic test_alias();
        int lat, rl; logic [W-1:0] xa, xb; logic [2:0] xo; logic [3:0][W-1:0] r;
        do_cmd(mk(1'b0, 3'b000, 2'd1, 2'd1, 2'd1, 2'd0), 0, lat, rl, xa, xb, xo);
        vectors++; if (xa !== 2'd1 || xb !== 2'd1) begin miscompares++; $display("FAIL alias_operands: got a=%0d b=%0d want 1/1", xa, xb); end
        read_regs(r);
        vectors++; if (r[1] !== 2'd2) begin miscompares++; $display("FAIL alias_r1: got %0d want 2", r[1]); end
        do_cmd(mk(1'b0, 3'b101, 2'd2, 2'd1, 2'd0, 2'd0), 0, lat, rl, xa, xb, xo);
        vectors++; if (last_result !== 2'd2 || xo !== 3'b101) begin miscompares++; $display("FAIL or_result: got res=%0d op=%0d want 2/5", last_result, xo); end
    endtask

    task automatic test_back_to_back();
        cmd_t cmds [5];
        int acc [5];
        int idx, cyc;
        logic [3:0][W-1:0] r;
        cmds[0] = mk(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 2'd0);
        cmds[1] = mk(1'b0, 3'b110, 2'd3, 2'd2, 2'd1, 2'd0);
        cmds[2] = mk(1'b0, 3'b001, 2'd0, 2'd3, 2'd2, 2'd0);
        cmds[3] = mk(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 2'd3);
        cmds[4] = mk(1'b0, 3'b011, 2'd2, 2'd1, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) acc[i] = 0;
        idx = 0; cyc = 0;
        @(negedge clk);
        // cmd_valid stays high; the next command (different rd) is presented while the previous one is busy
        while (idx < 5 && cyc < 100) begin
            cmd_load = cmds[idx].ld; cmd_op = cmds[idx].op; cmd_rd = cmds[idx].rd;
            cmd_ra = cmds[idx].ra; cmd_rb = cmds[idx].rb; cmd_imm = cmds[idx].imm;
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                acc[idx] = cyc;
                model_apply(cmds[idx], 0);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        vectors++; if (idx !== 5) begin miscompares++; $display("FAIL b2b_accepts: got %0d want 5", idx); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (acc[k+1] - acc[k] !== (cmds[k].ld ? 3 : 4)) begin
                miscompares++; $display("FAIL b2b_gap%0d: got %0d want %0d", k, acc[k+1] - acc[k], cmds[k].ld ? 3 : 4);
            end
        end
        for (int k = 0; k < 10 && !done; k++) @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_final_done: got %b want 1", done); end
        read_regs(r);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (r[i] !== m_regs[i]) begin miscompares++; $display("FAIL b2b_reg%0d: got %0d want %0d", i, r[i], m_regs[i]); end
        end
        vectors++; if (last_result !== m_last || last_ovf !== m_lovf || ovf_sticky !== m_sticky) begin
            miscompares++; $display("FAIL b2b_status: got %0d/%b/%b want %0d/%b/%b", last_result, last_ovf, ovf_sticky, m_last, m_lovf, m_sticky);
        end
    endtask

    task automatic test_random();
        cmd_t c; int lat, rl, clr_at;
        logic [W-1:0] ea, eb, xa, xb; logic [2:0] xo; logic [3:0][W-1:0] r;
        for (int n = 0; n < 60; n++) begin
            c = mk(1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), W'($urandom));
            clr_at = c.ld ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
            ea = m_regs[c.ra]; eb = m_regs[c.rb];
            do_cmd(c, clr_at, lat, rl, xa, xb, xo);
            vectors++; if (lat !== (c.ld ? 2 : 3)) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, c.ld ? 2 : 3); end
            vectors++; if (rl !== lat) begin miscompares++; $display("FAIL rnd%0d_ready_low: got %0d want %0d", n, rl, lat); end
            vectors++; if (last_result !== m_last || last_ovf !== m_lovf) begin miscompares++; $display("FAIL rnd%0d_last: got %0d/%b want %0d/%b", n, last_result, last_ovf, m_last, m_lovf); end
            vectors++; if (ovf_sticky !== m_sticky) begin miscompares++; $display("FAIL rnd%0d_sticky: got %b want %b", n, ovf_sticky, m_sticky); end
            if (!c.ld) begin
                vectors++; if (xa !== ea || xb !== eb || xo !== c.op) begin miscompares++; $display("FAIL rnd%0d_alu_drive: got %0d/%0d/%0d want %0d/%0d/%0d", n, xa, xb, xo, ea, eb, c.op); end
            end
            read_regs(r);
            for (int i = 0; i < 4; i++) begin
                vectors++; if (r[i] !== m_regs[i]) begin miscompares++; $display("FAIL rnd%0d_reg%0d: got %0d want %0d", n, i, r[i], m_regs[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, rl, guard; logic [W-1:0] xa, xb; logic [2:0] xo; logic [3:0][W-1:0] r;
        do_cmd(mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 2'd3), 0, lat, rl, xa, xb, xo);
        do_cmd(mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 2'd1), 0, lat, rl, xa, xb, xo);
        do_cmd(mk(1'b0, 3'b000, 2'd3, 2'd0, 2'd1, 2'd0), 0, lat, rl, xa, xb, xo);
        vectors++; if (ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_sticky: got %b want 1", ovf_sticky); end
        // ADD 3+1 into r2, reset while it is in EXEC
        @(negedge clk);
        cmd_load = 1'b0; cmd_op = 3'b000; cmd_rd = 2'd2; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done%0d: got %b want 0", k, done); end
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready: got rdy=%b done=%b want 1/0", cmd_ready, done); end
        vectors++; if (last_result !== '0 || ovf_sticky !== 1'b0 || last_ovf !== 1'b0) begin miscompares++; $display("FAIL rstmid_status: got %0d/%b/%b want 0/0/0", last_result, last_ovf, ovf_sticky); end
        read_regs(r);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (r[i] !== m_regs[i]) begin miscompares++; $display("FAIL rstmid_reg%0d: got %0d want %0d", i, r[i], m_regs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_sub();
        test_inc_clr();
        test_alias();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Sequencing stage directly upstream of the combinational 2-bit alu module. It drives that module's a, b and operation inputs and captures its result and overflow outputs.
- Holds a 4-entry register file (WIDTH bits per entry) and accepts one command at a time over a valid/ready handshake.
- A command either loads an immediate into a register or runs one ALU operation rd = ra OP rb.
- Reports completion with a one-cycle done pulse, last result/overflow, and a sticky overflow flag for board LEDs.

Parameters:
- WIDTH, 2, data width of registers and ALU operands; must match the alu module.
- REG_RESET, 0, reset value of every register-file entry.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  high only in IDLE; command accepted on an edge where cmd_valid & cmd_ready
- cmd_load  input  1  1 = load cmd_imm into rd; 0 = ALU operation
- cmd_op  input  3  ALU opcode forwarded unchanged to alu_op
- cmd_rd  input  2  destination register
- cmd_ra  input  2  operand A register
- cmd_rb  input  2  operand B register
- cmd_imm  input  WIDTH  immediate for load
- clr_ovf  input  1  clears ovf_sticky
- rd_sel  input  2  debug read select
- rd_data  output  WIDTH  combinational regs[rd_sel]
- alu_a  output  WIDTH  registered, to alu a
- alu_b  output  WIDTH  registered, to alu b
- alu_op  output  3  registered, to alu operation
- alu_result  input  WIDTH  from alu result
- alu_overflow  input  1  from alu overflow
- done  output  1  one-cycle pulse, command complete
- last_result  output  WIDTH  value written by last completed command
- last_ovf  output  1  overflow of last completed command (0 for loads)
- ovf_sticky  output  1  set by any captured overflow

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all regs=REG_RESET.
  - alu_a, alu_b, alu_op, last_result, last_ovf, ovf_sticky, done all 0.
  - cmd_ready=1 in the first cycle after reset deasserts.
- Reset mid-command: the command is abandoned. No done pulse, no writeback, and register contents return to REG_RESET.
- State machine:
  - IDLE -> READ on handshake edge E0. All cmd_* fields are latched at E0; later changes to cmd_* are ignored.
  - READ:
    - Load command: at E1, regs[rd]=imm, last_result=imm, last_ovf=0; -> DONE.
    - ALU command: at E1, alu_a=regs[ra], alu_b=regs[rb], alu_op=op; -> EXEC.
  - EXEC: alu inputs are stable for the full cycle. At E2, regs[rd]=alu_result, last_result=alu_result, last_ovf=alu_overflow; -> DONE.
  - DONE: done=1 for exactly this cycle; -> IDLE at the next edge.
- Latency from accept edge E0:
  - ALU command: done high in the cycle after E2 (3 cycles).
  - Load command: done high in the cycle after E1 (2 cycles).
  - Throughput: one command per 4 cycles (ALU) or 3 cycles (load).
- cmd_ready is 0 in READ, EXEC and DONE. cmd_valid is ignored while busy; the upstream holds the command until ready.
- ra, rb and rd may alias. Operands are sampled at E1, before the E2 writeback, so r1=r1+r1 uses the old r1.
- alu_a, alu_b and alu_op hold their last values outside READ→EXEC. No other output depends on them in IDLE.
- rd_data is combinational and reflects a writeback starting the cycle after the writing edge.
- ovf_sticky:
  - Set at E2 when alu_overflow=1.
  - Cleared by clr_ovf=1 at any edge.
  - If set and clear coincide on the same edge, set wins.
- Opcodes are passed through unmodified; the controller does not decode them. Overflow meaning is entirely the alu module's.
- Arithmetic wrap-around is the alu module's responsibility. Captured values are truncated to WIDTH.

Test Plan:
- Bench instantiates the alu module on the alu_* ports.
- Reset, then load r0=3 and r1=1 -> each load completes with done in cycle E0+2; rd_data(sel 0)=3, rd_data(sel 1)=1; last_ovf=0; cmd_ready low for exactly 2 cycles per load.
- ADD (op 000) rd=2, ra=0, rb=1 -> done at E0+3; r2=0, last_ovf=1, ovf_sticky=1. Then SUB (op 001) rd=3, ra=1, rb=0 -> r3=2, last_ovf=0, ovf_sticky stays 1.
- INC (op 010) rd=0, ra=0 with r0=3 -> r0=0 and last_ovf=1. Assert clr_ovf on the same edge as that capture -> ovf_sticky stays 1; clr_ovf one cycle later -> 0.
- Aliasing: r1=1, ADD rd=1, ra=1, rb=1 -> r1=2 (old value used for both operands). OR (op 101) r1|r0 with r0=0 -> 2.
- Backpressure: hold cmd_valid high with a second command during EXEC -> not accepted until IDLE. Change cmd_rd while busy -> no effect on the in-flight writeback. Back-to-back accepts are exactly 4 cycles apart.
- Reset asserted in EXEC of ADD 3+1 -> no done pulse; all regs, last_result and ovf_sticky = 0; cmd_ready=1 the cycle after reset releases.
